// File: rtl/dcache_if.sv
// ============================================================================
//  Module   : dcache_if
//  Purpose  : CPU-side and memory-side signal bundle for dcache_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dcache_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  // Controller side
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // CPU pipeline / backing memory side
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped write-back / write-allocate data cache controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic      clk,
  input  logic      rst,
  dcache_if.slave   bus
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TW-1:0]    r_tag  [LINES];
  logic [127:0]     r_data [LINES];

  // Miss index/tag are captured so the sequence completes even if the request drops
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_mtag;

  logic [IW-1:0]    w_idx;
  logic [TW-1:0]    w_tag;
  logic [1:0]       w_off;
  logic [127:0]     w_line;
  logic             w_hit;
  logic             w_unused_bits;

  assign w_idx         = bus.cpu_addr_i[3+IW:4];
  assign w_tag         = bus.cpu_addr_i[31:4+IW];
  assign w_off         = bus.cpu_addr_i[3:2];
  assign w_line        = r_data[w_idx];
  assign w_unused_bits = ^bus.cpu_addr_i[1:0];
  assign w_hit         = bus.cpu_req_i && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    bus.cpu_data_o  = '0;
    bus.cpu_stall_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    case (r_state)
      IDLE: begin
        if (w_hit)
          bus.cpu_data_o = w_line[{w_off, 5'b0} +: 32];
        bus.cpu_stall_o = bus.cpu_req_i && !w_hit;
      end
      WRITEBACK: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {r_tag[r_idx], r_idx, 4'b0};
        bus.mem_data_o  = r_data[r_idx];
      end
      ALLOCATE: begin
        bus.cpu_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = {r_mtag, r_idx, 4'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_idx   <= '0;
      r_mtag  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req_i) begin
            if (w_hit) begin
              if (bus.cpu_we_i)
                r_dirty[w_idx] <= 1'b1;
            end else begin
              r_idx   <= w_idx;
              r_mtag  <= w_tag;
              r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i)
            r_state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            r_valid[r_idx] <= 1'b1;
            r_dirty[r_idx] <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify their contents
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_hit && bus.cpu_we_i)
      r_data[w_idx][{w_off, 5'b0} +: 32] <= bus.cpu_data_i;
    else if (r_state == ALLOCATE && bus.mem_ack_i) begin
      r_data[r_idx] <= bus.mem_data_i;
      r_tag[r_idx]  <= r_mtag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Directed self-checking bench for dcache_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dcache_if bus ();

  dcache_ctrl #(.LINES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req_i  = req;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = data;
    #1;
  endtask

  logic [31:0]  held_addr;
  logic [127:0] held_data;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    bus.mem_data_i = '0;
    bus.mem_ack_i  = 1'b0;
    tick();
    tick();
    check("rst_mem_req",  {127'b0, bus.mem_req_o},   128'd0);
    check("rst_mem_we",   {127'b0, bus.mem_we_o},    128'd0);
    check("rst_mem_addr", {96'b0, bus.mem_addr_o},   128'd0);
    check("rst_mem_data", bus.mem_data_o,            128'd0);
    check("rst_cpu_data", {96'b0, bus.cpu_data_o},   128'd0);
    check("rst_stall",    {127'b0, bus.cpu_stall_o}, 128'd0);
    rst = 1'b0;
    tick();

    // Ack with no outstanding request is ignored
    bus.mem_ack_i = 1'b1;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("idle_ack_req",   {127'b0, bus.mem_req_o},   128'd0);
    check("idle_ack_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    bus.mem_ack_i = 1'b0;

    // Cold load miss at 0x100
    cpu(1'b1, 1'b0, 32'h100, 32'h0);
    check("cold_stall_now", {127'b0, bus.cpu_stall_o}, 128'd1);
    check("cold_cpu_data",  {96'b0, bus.cpu_data_o},   128'd0);
    tick();
    check("cold_alloc_req",  {127'b0, bus.mem_req_o}, 128'd1);
    check("cold_alloc_we",   {127'b0, bus.mem_we_o},  128'd0);
    check("cold_alloc_addr", {96'b0, bus.mem_addr_o}, 128'h100);
    tick();
    tick();
    bus.mem_data_i = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    bus.mem_ack_i  = 1'b1;
    #1;
    check("cold_stall_ack", {127'b0, bus.cpu_stall_o}, 128'd1);
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    check("cold_hit_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    check("cold_hit_data",  {96'b0, bus.cpu_data_o},   128'h11111111);
    check("cold_idle_req",  {127'b0, bus.mem_req_o},   128'd0);
    tick();
    cpu(1'b1, 1'b0, 32'h10C, 32'h0);
    check("hit_10c_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    check("hit_10c_data",  {96'b0, bus.cpu_data_o},   128'h44444444);
    tick();

    // Store hit then read back
    cpu(1'b1, 1'b1, 32'h104, 32'hDEADBEEF);
    check("store_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    tick();
    cpu(1'b1, 1'b0, 32'h104, 32'h0);
    check("store_rd_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    check("store_rd_data",  {96'b0, bus.cpu_data_o},   128'hDEADBEEF);
    tick();

    // Dirty eviction: 0x300 maps to index 16 with tag 1
    cpu(1'b1, 1'b0, 32'h300, 32'h0);
    check("dirty_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    tick();
    check("wb_req",  {127'b0, bus.mem_req_o},  128'd1);
    check("wb_we",   {127'b0, bus.mem_we_o},   128'd1);
    check("wb_addr", {96'b0, bus.mem_addr_o},  128'h100);
    check("wb_word1", {96'b0, bus.mem_data_o[63:32]}, 128'hDEADBEEF);
    check("wb_line", bus.mem_data_o, {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111});
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    check("wb2al_req",  {127'b0, bus.mem_req_o},   128'd1);
    check("wb2al_we",   {127'b0, bus.mem_we_o},    128'd0);
    check("wb2al_addr", {96'b0, bus.mem_addr_o},   128'h300);
    check("wb2al_data", bus.mem_data_o,            128'd0);
    check("wb2al_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    bus.mem_data_i = {32'h30303033, 32'h30303032, 32'h30303031, 32'h30303030};
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    check("dirty_done_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    check("dirty_done_data",  {96'b0, bus.cpu_data_o},   128'h30303030);
    tick();

    // Clean eviction of 0x300 by 0x500, with a slow memory
    cpu(1'b1, 1'b0, 32'h500, 32'h0);
    check("clean_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    tick();
    check("clean_we",   {127'b0, bus.mem_we_o},  128'd0);
    check("clean_addr", {96'b0, bus.mem_addr_o}, 128'h500);
    held_addr = bus.mem_addr_o;
    held_data = bus.mem_data_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("slow_req",   {127'b0, bus.mem_req_o},   128'd1);
      check("slow_addr",  {96'b0, bus.mem_addr_o},   {96'b0, held_addr});
      check("slow_data",  bus.mem_data_o,            held_data);
      check("slow_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    end
    bus.mem_data_i = {32'h50505053, 32'h50505052, 32'h50505051, 32'h50505050};
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    cpu(1'b1, 1'b0, 32'h508, 32'h0);
    check("clean_done_stall", {127'b0, bus.cpu_stall_o}, 128'd0);
    check("clean_done_data",  {96'b0, bus.cpu_data_o},   128'h50505052);
    tick();

    // Reset while in ALLOCATE
    cpu(1'b1, 1'b0, 32'h104, 32'h0);
    check("rmid_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    tick();
    check("rmid_req_before", {127'b0, bus.mem_req_o}, 128'd1);
    rst = 1'b1;
    #1;
    check("rmid_req_drop",  {127'b0, bus.mem_req_o},  128'd0);
    check("rmid_addr_zero", {96'b0, bus.mem_addr_o},  128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_stall", {127'b0, bus.cpu_stall_o}, 128'd1);
    tick();
    check("post_rst_addr", {96'b0, bus.mem_addr_o}, 128'h100);
    bus.mem_data_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus.mem_ack_i  = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    check("post_rst_data", {96'b0, bus.cpu_data_o}, 128'hA1);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    check("final_idle_stall", {127'b0, bus.cpu_stall_o}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU MEM stage and a wide backing memory. It serves single-word CPU loads and stores in zero extra cycles on a hit. On a miss it stalls the pipeline, writes back a dirty victim line if needed, and refills the line over a request/acknowledge memory handshake. It is the block that consumes the MEM stage's address, store data and control, and produces the load data that feeds the MEM/WB latch.

## Interface

- `LINES`, 32: number of cache lines; power of two; index width `IW = log2(LINES)`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset is asynchronous and active-high.
- `cpu_req_i`  in  1: MEM stage access valid.
- `cpu_we_i`  in  1: 1 = store, 0 = load.
- `cpu_addr_i`  in  32: byte address; bits [1:0] ignored; [3:2] word offset; [3+IW:4] index; [31:4+IW] tag.
- `cpu_data_i`  in  32: store data.
- `cpu_data_o`  out  32: load data; valid on a hit, 0 otherwise.
- `cpu_stall_o`  out  1: freeze PC and all pipeline latches while high.
- `mem_req_o`  out  1: backing-memory transaction request.
- `mem_we_o`  out  1: 1 = line write (writeback), 0 = line read (refill).
- `mem_addr_o`  out  32: line-aligned address; bits [3:0] = 0.
- `mem_data_o`  out  128: writeback line; word n at bits [32n+31:32n].
- `mem_data_i`  in  128: refill line, same word packing.
- `mem_ack_i`  in  1: one-cycle pulse completing the current transaction.

## Operation

- Per line: valid bit, dirty bit, tag (`28-IW` bits), 128-bit data.
- States: IDLE, WRITEBACK, ALLOCATE.
- Hit = `cpu_req_i` && valid[index] && tag match. Evaluated only in IDLE.
- IDLE, no request: `cpu_stall_o`=0; no state change.
- IDLE, load hit: `cpu_data_o` = selected word, combinationally from the array; `cpu_stall_o`=0.
- IDLE, store hit: `cpu_stall_o`=0; the selected word is replaced by `cpu_data_i` at the clock edge; dirty[index] is set.
- IDLE, miss: `cpu_stall_o`=1 in the same cycle.
  - Next state is WRITEBACK if the victim line is valid and dirty.
  - Otherwise next state is ALLOCATE.
- WRITEBACK:
  - Outputs: `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`={victim tag, index, 4'b0}, `mem_data_o`=victim line.
  - On `mem_ack_i` → ALLOCATE.
- ALLOCATE:
  - Outputs: `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={cpu tag, index, 4'b0}.
  - On `mem_ack_i`: line data ← `mem_data_i`, tag ← cpu tag, valid=1, dirty=0 → IDLE.
- After refill, the held request hits in IDLE and completes normally. A refill never merges store data; the store is applied on the following hit cycle.
- `cpu_stall_o`=1 in every WRITEBACK and ALLOCATE cycle.
- The CPU holds `cpu_req_i`, `cpu_we_i`, `cpu_addr_i` and `cpu_data_i` stable while stalled. If `cpu_req_i` drops mid-miss, the controller still completes the in-flight sequence and returns to IDLE.
- `mem_data_o` = 0 outside WRITEBACK. `mem_addr_o` = 0 and `mem_we_o` = 0 in IDLE.

## Timing

- Reset (async, immediate):
  - State = IDLE.
  - All valid and dirty bits cleared; dirty data is discarded.
  - Outputs: `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `cpu_data_o`=0.
  - `cpu_stall_o`=0 until a request arrives.
  - Tag and data arrays need not be reset.
- Reset during WRITEBACK or ALLOCATE: `mem_req_o` falls in the same cycle; the outstanding transaction is abandoned.
- Hit latency: 0 extra cycles.
- Clean miss: 1 detect cycle + N ALLOCATE cycles, where N counts up to and including the ack cycle. The request hits on the next cycle.
- Dirty miss: 1 + writeback cycles + allocate cycles, then the hit cycle.
- Handshake rules:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_data_o` are stable from request assertion through the ack cycle.
  - `mem_ack_i` is honoured only while `mem_req_o`=1; it is ignored in IDLE.
  - WRITEBACK→ALLOCATE keeps `mem_req_o` high. The new transaction begins the cycle after the ack, with `mem_we_o`=0 and the new address.
  - Zero-wait memory (ack in the first request cycle) is legal.

## Test plan

- **Cold load miss:** after reset, load 0x0000_0100.
  - `cpu_stall_o`=1 immediately.
  - ALLOCATE request at address 0x100 with `mem_we_o`=0.
  - Ack after 3 cycles with line {0x44444444,0x33333333,0x22222222,0x11111111}.
  - Next cycle: stall=0 and `cpu_data_o`=0x11111111. Load 0x10C then returns 0x44444444 with no stall.
- **Store hit:** store 0xDEADBEEF to 0x104 → no stall. Load 0x104 on the next cycle → 0xDEADBEEF.
- **Dirty eviction:** load 0x0000_0300 (same index 16, tag 1).
  - WRITEBACK at 0x100; `mem_data_o`[63:32]=0xDEADBEEF.
  - Then ALLOCATE at 0x300.
  - Stall ends one cycle after the ALLOCATE ack.
- **Clean eviction:** load 0x0000_0500 after a clean fill of 0x300 → no WRITEBACK; ALLOCATE at 0x500 directly.
- **Slow memory:** ack withheld for 10 cycles → `mem_req_o`, `mem_addr_o` and `mem_data_o` stay constant and stall stays high throughout.
- **Reset mid-ALLOCATE:** `mem_req_o` drops in the reset cycle. After release, load 0x104 misses again (valid cleared).
